// File: rtl/fetch_unit_pkg.sv
// Shared constants and slot layout for the simplearm front end.
// Used by the fetch stage and by the decode stage's pipeline registers.
package simplearm_pkg;

    localparam int INSTR_W = 32;
    localparam int XLEN    = 32;

    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               filled;
    } slot_t;

    localparam int SLOT_W = $bits(slot_t);

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

    // Instruction addresses are word aligned, so the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response channel between fetch and imem.
interface fetch_unit_if;
    import simplearm_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [XLEN-1:0]    imem_req_addr;
    logic               imem_resp_valid;
    logic [INSTR_W-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );

endinterface

// File: rtl/fetch_unit_buffer.sv
// Circular slot buffer for fetch: allocate on request, fill on response,
// pop to decode; a flush frees every slot and remembers stale responses.
module fetch_buffer
    import simplearm_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   alloc,
    input  logic [XLEN-1:0]        alloc_pc,
    input  logic                   resp_valid,
    input  logic [INSTR_W-1:0]     resp_data,
    input  logic                   pop,
    output slot_t                  head,
    output logic [$clog2(DEPTH):0] used,
    output logic [$clog2(DEPTH):0] drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    slot_t          slots [DEPTH];
    logic [PW-1:0]  alloc_ptr;
    logic [PW-1:0]  fill_ptr;
    logic [PW-1:0]  head_ptr;
    logic [CW-1:0]  used_q;
    logic [CW-1:0]  pend_q;
    logic [CW-1:0]  drop_q;
    logic           resp_drop;
    logic           resp_fill;
    logic           resp_taken;

    // Stale responses from before a redirect are always drained first.
    always_comb begin
        resp_drop  = resp_valid && (drop_q != '0);
        resp_fill  = resp_valid && (drop_q == '0) && (pend_q != '0);
        resp_taken = resp_drop || resp_fill;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            used_q    <= '0;
            pend_q    <= '0;
            drop_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i].filled <= 1'b0;
            end
        end else if (flush) begin
            // Everything still in flight, minus a response consumed right now, must be discarded later.
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            used_q    <= '0;
            pend_q    <= '0;
            drop_q    <= drop_q + pend_q - CW'(resp_taken);
            for (int i = 0; i < DEPTH; i++) begin
                slots[i].filled <= 1'b0;
            end
        end else begin
            if (alloc) begin
                slots[alloc_ptr].pc     <= alloc_pc;
                slots[alloc_ptr].instr  <= '0;
                slots[alloc_ptr].filled <= 1'b0;
                alloc_ptr               <= alloc_ptr + 1'b1;
            end
            if (resp_fill) begin
                slots[fill_ptr].instr  <= resp_data;
                slots[fill_ptr].filled <= 1'b1;
                fill_ptr               <= fill_ptr + 1'b1;
            end
            if (resp_drop) begin
                drop_q <= drop_q - 1'b1;
            end
            if (pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            used_q <= used_q + CW'(alloc) - CW'(pop);
            pend_q <= pend_q + CW'(alloc) - CW'(resp_fill);
        end
    end

    assign head     = slots[head_ptr];
    assign used     = used_q;
    assign drop_cnt = drop_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, imem request issue, redirect
// handling and the registered instr/pc/valid output towards decode.
module fetch_unit
    import simplearm_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    fetch_unit_if.master       imem,
    input  logic               branch_taken,
    input  logic [XLEN-1:0]    branch_target,
    input  logic               stall,
    output logic [INSTR_W-1:0] instr_out,
    output logic               valid_out,
    output logic [XLEN-1:0]    pc_out
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;

    logic [XLEN-1:0] pc;
    slot_t           head;
    logic [CW-1:0]   used;
    logic [CW-1:0]   drop_cnt;
    logic [OW-1:0]   occupancy;
    logic            pop;
    logic            has_space;
    logic            req_fire;

    // A slot popped this cycle is reusable by this cycle's request, which keeps one instruction per cycle.
    always_comb begin
        pop       = !stall && !branch_taken && head.filled && (used != '0);
        occupancy = {1'b0, used} + {1'b0, drop_cnt} - OW'(pop);
        has_space = occupancy < OW'(DEPTH);
    end

    assign imem.imem_req_valid = !rst && !branch_taken && has_space;
    assign imem.imem_req_addr  = pc;
    assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

    fetch_buffer #(
        .DEPTH(DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .flush      (branch_taken),
        .alloc      (req_fire),
        .alloc_pc   (pc),
        .resp_valid (imem.imem_resp_valid),
        .resp_data  (imem.imem_resp_data),
        .pop        (pop),
        .head       (head),
        .used       (used),
        .drop_cnt   (drop_cnt)
    );

    // Redirect outranks stall; a stalled decode keeps its current instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            instr_out <= '0;
            pc_out    <= '0;
            valid_out <= 1'b0;
        end else if (branch_taken) begin
            pc        <= align_pc(branch_target);
            valid_out <= 1'b0;
        end else begin
            if (req_fire) begin
                pc <= pc_next(pc);
            end
            if (!stall) begin
                if (pop) begin
                    instr_out <= head.instr;
                    pc_out    <= head.pc;
                    valid_out <= 1'b1;
                end else begin
                    valid_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for the basic stream, stall and
// redirect, then hand-written sequences with a latency-programmable memory model.
module tb_fetch_unit;
    import simplearm_pkg::*;

    localparam int              DEPTH    = 2;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] instr_out;
    logic        valid_out;
    logic [31:0] pc_out;

    fetch_unit_if mif();

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem         (mif),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .stall        (stall),
        .instr_out    (instr_out),
        .valid_out    (valid_out),
        .pc_out       (pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          cnt;
    } mem_entry_t;

    mem_entry_t mq[$];
    int         lat = 1;
    int         accepted = 0;

    // Memory model: returns addr+0x1000 in order, lat cycles after accept.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            accepted = 0;
            mif.imem_resp_valid <= 1'b0;
            mif.imem_resp_data  <= 32'h0;
        end else begin
            if (mif.imem_resp_valid) void'(mq.pop_front());
            foreach (mq[i]) if (mq[i].cnt > 0) mq[i].cnt = mq[i].cnt - 1;
            if (mif.imem_req_valid && mif.imem_req_ready) begin
                mq.push_back('{data: mif.imem_req_addr + 32'h1000, cnt: lat - 1});
                accepted = accepted + 1;
            end
            if (mq.size() > 0 && mq[0].cnt == 0) begin
                mif.imem_resp_valid <= 1'b1;
                mif.imem_resp_data  <= mq[0].data;
            end else begin
                mif.imem_resp_valid <= 1'b0;
                mif.imem_resp_data  <= 32'hDEAD_BEEF;
            end
        end
    end

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[$];
    int   vec_count  = 0;
    int   miscompares = 0;

    task automatic addVec(input logic s, input logic b, input logic [31:0] t, input logic rv,
                          input logic [31:0] addr, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr);
        vecs.push_back('{s, b, t, rv, addr, v, pc, instr});
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        stall         = v.stall;
        branch_taken  = v.br;
        branch_target = v.tgt;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic expectNextValid(input string name, input logic [31:0] exp_pc);
        int n = 0;
        while (valid_out !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (valid_out !== 1'b1) begin
            vec_count++;
            miscompares++;
            $display("[TB] FAIL %s timeout: valid_out stayed %b for 30 cycles, required 1", name, valid_out);
        end else begin
            checkOutput({name, " pc"}, pc_out, exp_pc);
            checkOutput({name, " instr"}, instr_out, exp_pc + 32'h1000);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int delivered;
        int max_occ;
        logic [31:0] exp_pc;

        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        mif.imem_req_ready = 1'b1;

        // Cycle table: stream start, 5-cycle stall, redirect to 0x102 (lat 1).
        addVec(0, 0, 0, 1, 32'h000, 0, 32'h000, 32'h0000);
        addVec(0, 0, 0, 1, 32'h004, 0, 32'h000, 32'h0000);
        addVec(0, 0, 0, 1, 32'h008, 0, 32'h000, 32'h0000);
        addVec(0, 0, 0, 1, 32'h00C, 1, 32'h000, 32'h1000);
        addVec(0, 0, 0, 1, 32'h010, 1, 32'h004, 32'h1004);
        for (int i = 0; i < 5; i++) addVec(1, 0, 0, 0, 32'h0, 1, 32'h008, 32'h1008);
        addVec(0, 0, 0, 1, 32'h014, 1, 32'h008, 32'h1008);
        addVec(0, 0, 0, 1, 32'h018, 1, 32'h00C, 32'h100C);
        addVec(0, 0, 0, 1, 32'h01C, 1, 32'h010, 32'h1010);
        addVec(0, 0, 0, 1, 32'h020, 1, 32'h014, 32'h1014);
        addVec(0, 1, 32'h102, 0, 32'h0, 1, 32'h018, 32'h1018);
        addVec(0, 0, 0, 1, 32'h100, 0, 32'h018, 32'h1018);
        addVec(0, 0, 0, 1, 32'h104, 0, 32'h018, 32'h1018);
        addVec(0, 0, 0, 1, 32'h108, 0, 32'h018, 32'h1018);
        addVec(0, 0, 0, 1, 32'h10C, 1, 32'h100, 32'h1100);
        addVec(0, 0, 0, 1, 32'h110, 1, 32'h104, 32'h1104);

        lat = 1;
        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            checkOutput($sformatf("v%0d valid_out", i), valid_out, vecs[i].exp_valid);
            checkOutput($sformatf("v%0d pc_out", i), pc_out, vecs[i].exp_pc);
            checkOutput($sformatf("v%0d instr_out", i), instr_out, vecs[i].exp_instr);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d req_valid", i), mif.imem_req_valid, vecs[i].exp_rv);
            if (vecs[i].exp_rv) checkOutput($sformatf("v%0d req_addr", i), mif.imem_req_addr, vecs[i].exp_addr);
            @(negedge clk);
        end
        stall = 1'b0; branch_taken = 1'b0;

        // Redirect with two requests in flight (lat 3), then back-to-back redirects.
        $display("[TB] redirect with two requests in flight");
        lat = 3;
        doReset();
        @(negedge clk);
        @(negedge clk);
        #1 checkOutput("B full req_valid", mif.imem_req_valid, 1'b0);
        branch_taken = 1'b1; branch_target = 32'h0000_0102;
        @(negedge clk);
        checkOutput("B valid after redirect", valid_out, 1'b0);
        branch_taken = 1'b0;
        #1 checkOutput("B req blocked by drops", mif.imem_req_valid, 1'b0);
        expectNextValid("B target", 32'h0000_0100);
        expectNextValid("B target+4", 32'h0000_0104);
        branch_taken = 1'b1; branch_target = 32'h0000_0300;
        @(negedge clk);
        branch_target = 32'h0000_0400;
        @(negedge clk);
        checkOutput("C valid after double redirect", valid_out, 1'b0);
        branch_taken = 1'b0;
        expectNextValid("C second target", 32'h0000_0400);
        expectNextValid("C second target+4", 32'h0000_0404);

        // Redirect coincident with stall and an arriving response.
        $display("[TB] redirect during stall with response arriving");
        lat = 1;
        doReset();
        repeat (6) @(negedge clk);
        checkOutput("D resp arriving", mif.imem_resp_valid, 1'b1);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0200;
        @(negedge clk);
        checkOutput("D valid after flush", valid_out, 1'b0);
        stall = 1'b0; branch_taken = 1'b0;
        expectNextValid("D target", 32'h0000_0200);
        expectNextValid("D target+4", 32'h0000_0204);

        // Random ready with 3-cycle memory: ordering and occupancy.
        $display("[TB] random ready, latency 3");
        lat = 3;
        doReset();
        delivered = 0;
        max_occ   = 0;
        exp_pc    = RESET_PC;
        for (int c = 0; c < 300; c++) begin
            if (valid_out) begin
                checkOutput($sformatf("E pc #%0d", delivered), pc_out, exp_pc);
                checkOutput($sformatf("E instr #%0d", delivered), instr_out, exp_pc + 32'h1000);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (accepted - delivered > max_occ) max_occ = accepted - delivered;
            mif.imem_req_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        mif.imem_req_ready = 1'b1;
        vec_count++;
        if (max_occ > DEPTH) begin
            miscompares++;
            $display("[TB] FAIL E occupancy: max %0d, limit %0d", max_occ, DEPTH);
        end
        vec_count++;
        if (delivered < 20) begin
            miscompares++;
            $display("[TB] FAIL E progress: delivered %0d, required at least 20", delivered);
        end

        // Reset mid-stream, then PC wrap at the top of the address space.
        $display("[TB] reset mid-stream and pc wrap");
        lat = 1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1 checkOutput("F req_valid in reset", mif.imem_req_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("F valid after reset", valid_out, 1'b0);
        checkOutput("F pc after reset", pc_out, 32'h0);
        checkOutput("F instr after reset", instr_out, 32'h0);
        #1 checkOutput("F first req_valid", mif.imem_req_valid, 1'b1);
        checkOutput("F first req_addr", mif.imem_req_addr, RESET_PC);
        expectNextValid("F first", RESET_PC);
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8;
        @(negedge clk);
        branch_taken = 1'b0;
        checkOutput("F valid after redirect", valid_out, 1'b0);
        expectNextValid("F wrap -8", 32'hFFFF_FFF8);
        expectNextValid("F wrap -4", 32'hFFFF_FFFC);
        expectNextValid("F wrap 0", 32'h0000_0000);
        expectNextValid("F wrap 4", 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
